// File: rtl/mem_port_arb_pkg.sv
// Shared types and default sizing for the memory port arbiter and its
// round-robin sub-arbiter.
package mem_port_arb_pkg;

    localparam int unsigned DEF_NRD = 4;
    localparam int unsigned DEF_NWR = 2;
    localparam int unsigned DEF_AW  = 8;
    localparam int unsigned DEF_DW  = 64;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    // Pointer width for an N-way arbiter; a 1-way arbiter still needs one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arb_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or above
// ptr (wrapping) and returns the pointer to use on the following cycle.
module rr_arb
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr_nxt
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt     = '0;
        ptr_nxt = ptr;
        idx     = 0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_nxt  = PW'((idx + 1) % N);
            end
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Memory port arbiter: clears the memory after reset, then arbitrates one read
// and one write per cycle (independent round-robin) onto a single memory port.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned NRD = DEF_NRD,
    parameter int unsigned NWR = DEF_NWR,
    parameter int unsigned AW  = DEF_AW,
    parameter int unsigned DW  = DEF_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD-1:0]    rd_valid,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_ready,
    output logic [NRD-1:0]    rsp_valid,
    output logic [DW-1:0]     rsp_data,
    input  logic [NWR-1:0]    wr_valid,
    output logic [NWR-1:0]    wr_ready,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    output logic              mem_re,
    output logic [AW-1:0]     mem_raddr,
    input  logic [DW-1:0]     mem_rdata,
    output logic              mem_we,
    output logic [AW-1:0]     mem_waddr,
    output logic [DW-1:0]     mem_wdata,
    output logic              init_done
);

    localparam int unsigned RPW = ptr_w(NRD);
    localparam int unsigned WPW = ptr_w(NWR);

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [RPW-1:0]  rd_ptr, rd_ptr_nxt;
    logic [WPW-1:0]  wr_ptr, wr_ptr_nxt;
    logic            run;
    logic [NRD-1:0]  rd_req, rd_gnt;
    logic [NWR-1:0]  wr_req, wr_gnt;
    logic [NRD-1:0]  rsp_q;
    logic [DW-1:0]   rsp_hold;

    // Requests are masked outside RUN so the arbiters neither grant nor move
    // their pointers during clear or while reset is held.
    assign run    = rst_n && (state == RUN);
    assign rd_req = rd_valid & {NRD{run}};
    assign wr_req = wr_valid & {NWR{run}};

    rr_arb #(.N(NRD), .PW(RPW)) u_rd_arb (
        .req     (rd_req),
        .ptr     (rd_ptr),
        .gnt     (rd_gnt),
        .ptr_nxt (rd_ptr_nxt)
    );

    rr_arb #(.N(NWR), .PW(WPW)) u_wr_arb (
        .req     (wr_req),
        .ptr     (wr_ptr),
        .gnt     (wr_gnt),
        .ptr_nxt (wr_ptr_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            cnt      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            rsp_q    <= '0;
            rsp_hold <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
            rsp_q  <= rd_gnt;
            if (|rsp_q) begin
                rsp_hold <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_ready  = rd_gnt;
        wr_ready  = wr_gnt;
        mem_re    = |rd_gnt;
        mem_raddr = '0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        init_done = 1'b0;

        for (int unsigned i = 0; i < NRD; i++) begin
            if (rd_gnt[i]) begin
                mem_raddr = rd_addr[i*AW +: AW];
            end
        end

        case (state)
            INIT: begin
                mem_we    = rst_n;
                mem_waddr = cnt;
                cnt_nxt   = cnt + AW'(1);
                if (cnt == '1) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                init_done = rst_n;
                mem_we    = |wr_gnt;
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (wr_gnt[j]) begin
                        mem_waddr = wr_addr[j*AW +: AW];
                        mem_wdata = wr_data[j*DW +: DW];
                    end
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // Read data arrives from memory one cycle after the grant; it is passed
    // straight through then and held afterwards. Reset kills any in-flight response.
    assign rsp_valid = rsp_q & {NRD{rst_n}};
    assign rsp_data  = !rst_n ? '0 : ((|rsp_q) ? mem_rdata : rsp_hold);

endmodule

// File: tb/tb_mem_port_arb.sv
// Scoreboard bench for mem_port_arb: directed stimulus pushes expected read
// responses; a negedge monitor pops and compares them as rsp_valid appears.
module tb_mem_port_arb;

    localparam int unsigned NRD = 4;
    localparam int unsigned NWR = 2;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD-1:0]    rd_valid;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD-1:0]    rd_ready;
    logic [NRD-1:0]    rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [NWR-1:0]    wr_valid;
    logic [NWR-1:0]    wr_ready;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              mem_re;
    logic [AW-1:0]     mem_raddr;
    logic [DW-1:0]     mem_rdata = '0;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic              init_done;

    always #5 clk = ~clk;

    mem_port_arb #(.NRD(NRD), .NWR(NWR), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .init_done (init_done)
    );

    // Registered-read memory; a same-edge write is not seen by the read.
    logic [DW-1:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = {32'hBAD0BAD0, 24'h0, 8'(i)};
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_raddr];
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    typedef struct {
        int unsigned   id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        #1;
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", DW'(rsp_valid), '0);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", DW'(rsp_valid), DW'(1 << e.id));
                chk("rsp_data", rsp_data, e.data);
            end
        end
    end

    // Releases reset on the first negedge, then checks n clear cycles.
    task automatic run_init(input int unsigned n);
        for (int unsigned c = 0; c < n; c++) begin
            @(negedge clk);
            if (c == 0) rst_n = 1'b1;
            if (c == 255) begin
                rd_valid = '0;
                wr_valid = '0;
            end
            #1;
            chk("init_ctl", DW'({mem_we, mem_re, init_done, rd_ready, wr_ready, mem_waddr}),
                DW'({1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 8'(c)}));
            chk("init_wdata", mem_wdata, '0);
        end
    endtask

    task automatic chk_init_done();
        @(negedge clk);
        #1;
        chk("init_done", DW'({init_done, mem_we, rd_ready, wr_ready}), DW'(8'b1000_0000));
    endtask

    logic [AW-1:0] rd_tab_addr [4] = '{8'h40, 8'h51, 8'h42, 8'h53};
    logic [DW-1:0] rd_tab_data [4] = '{64'hA0, 64'hB1, 64'hA2, 64'hB3};

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        int unsigned g;
        rst_n    = 1'b0;
        rd_valid = '1;
        wr_valid = '1;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", DW'({rd_ready, wr_ready, mem_re, mem_we, init_done, rsp_valid}), '0);
        chk("rst_rsp_data", rsp_data, '0);

        run_init(256);
        chk_init_done();

        // Both writers every cycle: alternate 0,1,0,1
        for (int unsigned j = 0; j < 4; j++) begin
            @(negedge clk);
            wr_valid = 2'b11;
            wr_addr  = {8'(8'h50 + j), 8'(8'h40 + j)};
            wr_data  = {64'(64'hB0 + j), 64'(64'hA0 + j)};
            #1;
            g = j % 2;
            chk("wr_alt_ready", DW'(wr_ready), DW'(1 << g));
            chk("wr_alt_addr", DW'(mem_waddr), (g == 1) ? DW'(8'h50 + j) : DW'(8'h40 + j));
            chk("wr_alt_data", mem_wdata, (g == 1) ? DW'(64'hB0 + j) : DW'(64'hA0 + j));
        end

        // Write then read-after-write
        @(negedge clk);
        wr_valid = 2'b01;
        wr_addr[7:0] = 8'h10;
        wr_data[63:0] = 64'hDEADBEEF_00000001;
        #1;
        chk("raw_wr", DW'({wr_ready, mem_we, mem_waddr}), DW'({2'b01, 1'b1, 8'h10}));
        chk("raw_wdata", mem_wdata, 64'hDEADBEEF_00000001);
        @(negedge clk);
        wr_valid = '0;
        rd_valid = 4'b0100;
        rd_addr[2*AW +: AW] = 8'h10;
        #1;
        chk("raw_rd", DW'({rd_ready, mem_re, mem_raddr}), DW'({4'b0100, 1'b1, 8'h10}));
        sb.push_back('{2, 64'hDEADBEEF_00000001});

        // Same-cycle read/write to one address returns old data
        @(negedge clk);
        rd_valid = 4'b0001;
        rd_addr[7:0] = 8'h20;
        wr_valid = 2'b01;
        wr_addr[7:0] = 8'h20;
        wr_data[63:0] = 64'h5;
        #1;
        chk("coll_grants", DW'({rd_ready, wr_ready}), DW'({4'b0001, 2'b01}));
        sb.push_back('{0, 64'h0});
        @(negedge clk);
        wr_valid = '0;
        #1;
        chk("coll_reread", DW'(rd_ready), DW'(4'b0001));
        sb.push_back('{0, 64'h5});
        @(negedge clk);
        rd_valid = '0;
        #1;
        chk("idle_ready", DW'(rd_ready), '0);

        // Single grant to reader 3 brings the read pointer back to 0
        @(negedge clk);
        rd_valid = 4'b1000;
        rd_addr  = {rd_tab_addr[3], rd_tab_addr[2], rd_tab_addr[1], rd_tab_addr[0]};
        #1;
        chk("rd3_ready", DW'(rd_ready), DW'(4'b1000));
        sb.push_back('{3, rd_tab_data[3]});

        // All readers back-to-back with a concurrent write stream
        for (int unsigned k = 0; k < 8; k++) begin
            @(negedge clk);
            rd_valid = '1;
            wr_valid = 2'b10;
            wr_addr[15:8]   = 8'(8'h60 + k);
            wr_data[127:64] = 64'(64'hC0 + k);
            #1;
            g = k % 4;
            chk("rr_ready", DW'(rd_ready), DW'(1 << g));
            chk("rr_raddr", DW'({mem_re, mem_raddr}), DW'({1'b1, rd_tab_addr[g]}));
            chk("rr_wr", DW'({wr_ready, mem_we, mem_waddr}), DW'({2'b10, 1'b1, 8'(8'h60 + k)}));
            sb.push_back('{g, rd_tab_data[g]});
        end
        @(negedge clk);
        wr_valid = '0;
        rd_valid = 4'b0010;
        rd_addr[15:8] = 8'h67;
        #1;
        chk("stream_rd", DW'(rd_ready), DW'(4'b0010));
        sb.push_back('{1, 64'hC7});
        @(negedge clk);
        rd_valid = '0;
        @(negedge clk);
        #1;
        chk("rsp_hold", rsp_data, 64'hC7);
        chk("rsp_idle", DW'(rsp_valid), '0);

        // Grant, then reset before its response: response must vanish
        @(negedge clk);
        rd_valid = 4'b0001;
        rd_addr[7:0] = 8'h40;
        #1;
        chk("drop_grant", DW'(rd_ready), DW'(4'b0001));
        @(negedge clk);
        rd_valid = '1;
        wr_valid = '1;
        rst_n    = 1'b0;
        #1;
        chk("drop_outs", DW'({rsp_valid, rd_ready, wr_ready, mem_we, mem_re, init_done}), '0);

        // Reset mid-clear at counter 100 restarts from address 0
        run_init(100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midinit_rst", DW'({mem_we, init_done, rd_ready, wr_ready}), '0);
        run_init(256);
        chk_init_done();

        // Pointers were reset: both arbiters start from port 0
        @(negedge clk);
        rd_valid = '1;
        wr_valid = '1;
        rd_addr[7:0] = 8'h40;
        wr_addr = {8'h70, 8'h71};
        wr_data = {64'h8, 64'h9};
        #1;
        chk("ptr_reset", DW'({rd_ready, wr_ready, mem_waddr}), DW'({4'b0001, 2'b01, 8'h71}));
        sb.push_back('{0, 64'h0});
        @(negedge clk);
        rd_valid = '0;
        wr_valid = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("sb_empty", DW'(sb.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter NRD, default 4, number of read requesters.
REQ-002 SHALL have parameter NWR, default 2, number of write requesters.
REQ-003 SHALL have parameter AW, default 8, memory address width (256 entries).
REQ-004 SHALL have parameter DW, default 64, memory data width.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 rd_valid  in  NRD  per-requester read request.
REQ-008 rd_addr  in  NRD*AW  per-requester read address, requester i at bits [i*AW +: AW].
REQ-009 rd_ready  out  NRD  one-hot read grant; a request is accepted when rd_valid[i] and rd_ready[i] are both high.
REQ-010 rsp_valid  out  NRD  one-hot; marks the response for the requester accepted in the previous cycle.
REQ-011 rsp_data  out  DW  shared read response data.
REQ-012 wr_valid / wr_ready  in / out  NWR / NWR  per-writer request and one-hot grant.
REQ-013 wr_addr / wr_data  in  NWR*AW / NWR*DW  per-writer address and data.
REQ-014 mem_re, mem_raddr  out  1, AW  memory read port; the memory registers read data 1 cycle later.
REQ-015 mem_rdata  in  DW  memory read data.
REQ-016 mem_we, mem_waddr, mem_wdata  out  1, AW, DW  memory write port.
REQ-017 init_done  out  1  high once memory clear has completed.

Function
REQ-018 FSM SHALL have states INIT and RUN; reset SHALL enter INIT with clear counter = 0.
REQ-019 In INIT, the block SHALL issue mem_we=1, mem_waddr=counter, mem_wdata=0 each cycle and increment the counter.
REQ-020 In INIT, rd_ready=0, wr_ready=0, mem_re=0 and init_done=0.
REQ-021 After writing address 2^AW-1, the FSM SHALL go to RUN on the next cycle and set init_done=1; INIT lasts exactly 2^AW cycles.
REQ-022 In RUN, the read arbiter SHALL grant at most one rd_valid per cycle, round-robin, searching upward from the priority pointer.
REQ-023 After a grant to requester g, the read pointer SHALL become (g+1) mod NRD; with no grant, the pointer SHALL hold.
REQ-024 rd_ready SHALL be combinational from rd_valid and the pointer, never high for a non-requesting port, and no port SHALL wait more than NRD-1 grants.
REQ-025 On a read grant, mem_re=1 and mem_raddr=the granted address in the same cycle.
REQ-026 In the following cycle, rsp_valid[g]=1 and rsp_data=mem_rdata; responses SHALL NOT be back-pressured.
REQ-027 rsp_data SHALL hold its last value when rsp_valid=0.
REQ-028 The write arbiter SHALL be independent of the read arbiter, round-robin over NWR with identical pointer rules, and drive mem_we/mem_waddr/mem_wdata in the grant cycle.
REQ-029 A read and a write granted in the same cycle to the same address SHALL return the old data; no forwarding is done.
REQ-030 A back-to-back read grant every cycle SHALL be sustained, giving throughput of 1 read and 1 write per cycle.

Reset
REQ-031 While rst_n=0: rsp_valid=0, rsp_data=0, rd_ready=0, wr_ready=0, mem_re=0, mem_we=0, init_done=0, and both pointers=0.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL restart INIT at address 0; any in-flight response SHALL be dropped.

Structure
REQ-033 Package mem_port_arb_pkg SHALL hold the state enum (INIT, RUN) and the default AW/DW/NRD/NWR constants.
REQ-034 Sub-module rr_arb (parameter N; inputs req, ptr; outputs one-hot gnt and next ptr) SHALL be instantiated twice, once for reads and once for writes.

Verification
REQ-035 Reset, then idle -> mem_we high for 256 cycles at addresses 0..255 with data 0; init_done rises on cycle 257; no grants before then.
REQ-036 All 4 readers request continuously with pointer=0 -> grants 0,1,2,3,0,...; each rsp_valid follows its grant by 1 cycle.
REQ-037 Writer 0 writes 0xDEADBEEF_00000001 to addr 0x10; reader 2 reads 0x10 next cycle -> rsp_valid[2] with that data.
REQ-038 Same cycle: write 0x5 to addr 0x20 and read addr 0x20 -> response returns 0 (old data); a read one cycle later returns 0x5.
REQ-039 Both writers request every cycle -> grants alternate 0,1,0,1.
REQ-040 rst_n pulsed low at clear counter 100 -> counter restarts at 0; the full 256-cycle INIT repeats; a pending response is suppressed.
